// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse-train measurement block.
//   state_e      : FSM state encoding (IDLE=0, MEASURE=1, TIMED_OUT=2)
//   period_width : width of a period value able to hold 0..max_period
package pulse_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEASURE   = 2'd1,
        ST_TIMED_OUT = 2'd2
    } state_e;

    function automatic int period_width(input int max_period);
        return $clog2(max_period + 1);
    endfunction

endpackage

// File: rtl/pulse_period_meter_if.sv
// Pulse-train measurement interface.
//   PULSE_IN     : async pulse train (rising edge is the event)
//   PERIOD_OUT   : last measured period in clock cycles
//   PERIOD_VALID : one-cycle strobe, PERIOD_OUT updated
//   LOCKED       : consecutive periods agree within tolerance
//   TIMEOUT      : no edge seen within the maximum period
// master drives the pulse train and observes results; slave is the meter.
interface pulse_period_meter_if
    import pulse_period_meter_pkg::*;
#(
    parameter int W = period_width(1024)
);
    logic         PULSE_IN;
    logic [W-1:0] PERIOD_OUT;
    logic         PERIOD_VALID;
    logic         LOCKED;
    logic         TIMEOUT;

    modport master (
        output PULSE_IN,
        input  PERIOD_OUT, PERIOD_VALID, LOCKED, TIMEOUT
    );

    modport slave (
        input  PULSE_IN,
        output PERIOD_OUT, PERIOD_VALID, LOCKED, TIMEOUT
    );
endinterface

// File: rtl/pulse_period_meter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
//   CLK_IN  : clock
//   RST_IN  : synchronous active-high reset
//   async_i : asynchronous level input
//   rise_o  : one-cycle pulse, three clock edges after async_i is first sampled high
module edge_sync (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic async_i,
    output logic rise_o
);
    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic rise_q;

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= sync2_q & ~sync3_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/pulse_period_meter.sv
// Measures the period of a pulse train in CLK_IN cycles, strobes each
// completed period, flags lock when consecutive periods agree within
// TOLERANCE and flags timeout when no edge arrives within MAX_PERIOD cycles.
//   CLK_IN : clock
//   RST_IN : synchronous active-high reset
//   bus    : slave side of pulse_period_meter_if (W must equal period_width(MAX_PERIOD))
//
// state        | meaning
// ST_IDLE      | after reset, waiting for the first edge (no period yet)
// ST_MEASURE   | counting cycles since the last edge
// ST_TIMED_OUT | MAX_PERIOD elapsed without an edge, TIMEOUT held high
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int MAX_PERIOD = 1024,
    parameter int TOLERANCE  = 0
) (
    input  logic                  CLK_IN,
    input  logic                  RST_IN,
    pulse_period_meter_if.slave   bus
);
    localparam int             W       = period_width(MAX_PERIOD);
    localparam logic [W-1:0]   CNT_MAX = W'(MAX_PERIOD - 1);
    localparam logic [W:0]     TOL_W   = (W+1)'(TOLERANCE);

    logic rise;

    edge_sync u_edge_sync (
        .CLK_IN  (CLK_IN),
        .RST_IN  (RST_IN),
        .async_i (bus.PULSE_IN),
        .rise_o  (rise)
    );

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] prev_q, prev_d;
    logic         prev_vld_q, prev_vld_d;
    logic         valid_q, valid_d;
    logic         locked_q, locked_d;
    logic         timeout_q, timeout_d;

    logic [W-1:0]      cnt_inc;
    logic signed [W:0] diff;
    logic [W:0]        abs_diff;

    // cnt_inc never exceeds MAX_PERIOD, so it always fits in W bits; the
    // difference gets one extra sign bit so it cannot wrap.
    assign cnt_inc  = cnt_q + W'(1);
    assign diff     = $signed({1'b0, cnt_inc}) - $signed({1'b0, prev_q});
    assign abs_diff = diff[W] ? $unsigned(-diff) : $unsigned(diff);

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;

        if (rise)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_inc;

        unique case (state_q)
            ST_IDLE: begin
                if (rise)
                    state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                // rise wins over saturation: an edge at cnt == MAX_PERIOD-1
                // is a valid period of exactly MAX_PERIOD.
                if (rise) begin
                    period_d   = cnt_inc;
                    valid_d    = 1'b1;
                    prev_d     = cnt_inc;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q)
                        locked_d = (abs_diff <= TOL_W);
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ST_TIMED_OUT;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    prev_vld_d = 1'b0;
                end
            end
            ST_TIMED_OUT: begin
                // The interval closed by this edge is not a real period.
                if (rise) begin
                    timeout_d = 1'b0;
                    state_d   = ST_MEASURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.PERIOD_OUT   = period_q;
    assign bus.PERIOD_VALID = valid_q;
    assign bus.LOCKED       = locked_q;
    assign bus.TIMEOUT      = timeout_q;
endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Receiving end of the pulse-train interface: measures the period of a pulse train arriving on `PULSE_IN`, counted in `CLK_IN` cycles. It reports each completed period with a one-cycle strobe and flags lock when successive periods agree. It also flags timeout when the train stops. It sits downstream of the `pulse` divider, or of any external tick source, for frequency checking and tick-rate monitoring.

## Interface
- `MAX_PERIOD`, default 1024: longest measurable period in cycles; reaching it without an edge is a timeout.
- `TOLERANCE`, default 0: maximum absolute difference between consecutive periods that still counts as "equal" for lock.
- `CLK_IN`  input  1  the single clock for the block.
- `RST_IN`  input  1  reset; synchronous, active-high.
- `PULSE_IN`  input  1  pulse train, asynchronous to `CLK_IN`; the rising edge is the event.
- `PERIOD_OUT`  output  W  last measured period in cycles, where W = $clog2(MAX_PERIOD+1).
- `PERIOD_VALID`  output  1  one-cycle strobe; `PERIOD_OUT` was updated this cycle.
- `LOCKED`  output  1  consecutive periods agree within `TOLERANCE`.
- `TIMEOUT`  output  1  no edge was seen within `MAX_PERIOD` cycles.

## Operation
- Input path: `PULSE_IN` passes through a 2-FF synchronizer, then a registered rising-edge detector. The detector produces the internal one-cycle `rise` signal.
- Cycle counter `cnt`, W bits:
  - cleared to 0 in the cycle `rise` is high;
  - increments by 1 in every other cycle;
  - saturates at `MAX_PERIOD-1`.
- FSM states: IDLE, MEASURE, TIMED_OUT. Encoding is 2 bits.
  - IDLE: entered from reset. Waits for the first `rise`. On `rise`: clear `cnt`, go to MEASURE. No strobe is issued.
  - MEASURE, on `rise`:
    - `PERIOD_OUT` <= `cnt`+1;
    - `PERIOD_VALID` <= 1;
    - `prev` <= `cnt`+1;
    - `cnt` <= 0.
  - MEASURE, when `cnt` == `MAX_PERIOD-1` with no `rise`: go to TIMED_OUT. Set `TIMEOUT`=1 and `LOCKED`=0.
  - TIMED_OUT: `TIMEOUT` stays 1. On `rise`: clear `cnt`, clear `TIMEOUT`, go to MEASURE. No strobe is issued, because the interval being closed is not a valid period.
- Lock rule, evaluated on each strobe that has a valid `prev`:
  - |(`cnt`+1) − `prev`| <= `TOLERANCE` → `LOCKED` <= 1.
  - Otherwise → `LOCKED` <= 0.
  - The first strobe after IDLE or TIMED_OUT has no valid `prev`, so it never sets `LOCKED`.
- Width rule: the difference is computed in W+1 bits, signed, then its absolute value is taken. No wrap-around is allowed.
- Simultaneous events: `rise` in the same cycle that `cnt` reaches `MAX_PERIOD-1` counts as a valid edge. A strobe of `MAX_PERIOD` is issued and there is no timeout.
- Reset values, applied in any state including mid-period:
  - state = IDLE;
  - `cnt` = 0;
  - synchronizer and edge registers = 0;
  - `PERIOD_OUT` = 0, `PERIOD_VALID` = 0, `LOCKED` = 0, `TIMEOUT` = 0;
  - `prev` invalid.

## Timing
- Input-to-`rise` latency: 3 `CLK_IN` edges after `PULSE_IN` is first sampled high (2 synchronizer stages plus 1 edge stage).
- `PERIOD_VALID` and the new `PERIOD_OUT` are registered and appear 1 cycle after `rise`.
- Latency is constant, so the measured period equals the true period in cycles.
- `PERIOD_OUT` holds its value between strobes.
- `LOCKED` updates in the same cycle as `PERIOD_VALID`.
- `TIMEOUT` rises exactly `MAX_PERIOD` cycles after the last `rise`.
- Minimum resolvable period is 2 cycles. `PULSE_IN` must stay low for at least 1 cycle between edges.
- A high level held across many cycles is one edge.

## Structure
- Shared header `pulse_defs.vh` holds:
  - FSM state constants (IDLE=0, MEASURE=1, TIMED_OUT=2);
  - the width function/localparam derivation used by both `pulse` and this block.
- Sub-module `edge_sync`: the 2-FF synchronizer plus rising-edge register. It is parameterless, takes `CLK_IN`, `RST_IN`, and the async input, and outputs `rise`. It is reusable for other async strobes.
- The top level holds the FSM, counter, lock comparator and output registers.

## Test plan
- Reset, then `pulse` with FREQ_IN=1000, FREQ_OUT=100 driving `PULSE_IN`:
  - first edge gives no strobe;
  - then a strobe every 10 cycles with `PERIOD_OUT`=10;
  - `LOCKED`=1 from the second strobe on;
  - `TIMEOUT`=0 throughout.
- Periods 10, 10, 13 with `TOLERANCE`=2: `LOCKED` goes 1 then 0, and `PERIOD_OUT`=13. Repeat with `TOLERANCE`=3: `LOCKED` stays 1.
- MAX_PERIOD=16, then stop the input:
  - `TIMEOUT`=1 exactly 16 cycles after the last `rise`, and `LOCKED`=0;
  - the next edge clears `TIMEOUT` with no strobe;
  - the following edge 8 cycles later gives `PERIOD_OUT`=8.
- MAX_PERIOD=16 and period exactly 16: `rise` coincides with saturation. The strobe gives `PERIOD_OUT`=16 and `TIMEOUT` stays 0.
- Assert `RST_IN` for 1 cycle mid-period while `LOCKED`=1:
  - next cycle all outputs are 0 and state is IDLE;
  - the first post-reset edge gives no strobe.
- Drive `PULSE_IN` high for 7 cycles, low for 3, repeating: one strobe per 10 cycles with `PERIOD_OUT`=10. No extra strobes from the held-high level.
